// File: rtl/cone_eval_arbiter.sv
// Round-robin arbiter sharing one combinational cone evaluator among NUM_REQ requesters.
// Drives the cone from a register, waits SETTLE_CYC cycles, then returns the captured result.
module cone_eval_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IN_W       = 9,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_vec,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         cone_in,
    input  logic                    cone_out,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic                    rsp_data,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    busy,
    output logic [2:0]              grant_id,
    output logic [7:0]              done_cnt
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("cone_eval_arbiter: SETTLE_CYC must be at least 1");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("cone_eval_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] win;
    logic             any_valid;
    logic             accept;
    logic             rsp_done;
    int               win_dist;
    int               best_dist;
    logic [IN_W-1:0]  vec_arr [NUM_REQ];

    // Unpack the flat request bus into per-requester vectors
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign vec_arr[g] = req_vec[g*IN_W +: IN_W];
    end

    // Round-robin pick: smallest distance after last_q wins
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        win_dist  = 0;
        best_dist = int'(NUM_REQ);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_dist = (i + int'(NUM_REQ) - 1 - int'(last_q)) % int'(NUM_REQ);
            if (req_valid[i] && (win_dist < best_dist)) begin
                best_dist = win_dist;
                win       = IDX_W'(i);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state and combinational accept strobe
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready = NUM_REQ'(1) << win;
                    accept    = 1'b1;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: cone drive, settle counter, response capture, bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cone_in   <= '0;
            rsp_data  <= 1'b0;
            rsp_valid <= '0;
            busy      <= 1'b0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            done_cnt  <= '0;
        end else begin
            busy <= (state_d != IDLE);
            if (accept) begin
                cone_in <= vec_arr[win];
                grant_q <= win;
                cnt_q   <= CNT_W'(SETTLE_CYC - 1);
            end
            if (state_q == SETTLE) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    rsp_data  <= cone_out;
                    rsp_valid <= NUM_REQ'(1) << grant_q;
                end
            end
            if (rsp_done) begin
                rsp_valid <= '0;
                last_q    <= grant_q;
                done_cnt  <= done_cnt + 8'd1;
            end
        end
    end

    assign grant_id = 3'(grant_q);

endmodule

// File: tb/tb_cone_eval_arbiter.sv
// Bench for cone_eval_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model; a second instance with SETTLE_CYC=1 covers the counter wrap.
module tb_cone_eval_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 9;
    localparam int unsigned SC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*W-1:0] req_vec;
    logic [W-1:0]    cone_in;
    logic            cone_out, rsp_data, busy;
    logic [2:0]      grant_id;
    logic [7:0]      done_cnt;

    logic [NR-1:0]   req_valid1, req_ready1, rsp_valid1, rsp_ready1;
    logic [NR*W-1:0] req_vec1;
    logic [W-1:0]    cone_in1;
    logic            cone_out1, rsp_data1, busy1;
    logic [2:0]      grant_id1;
    logic [7:0]      done_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Cone stand-in: odd parity of the driven inputs
    assign cone_out  = ^cone_in;
    assign cone_out1 = ^cone_in1;

    cone_eval_arbiter #(.NUM_REQ(NR), .IN_W(W), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vec(req_vec),
        .req_ready(req_ready), .cone_in(cone_in), .cone_out(cone_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .grant_id(grant_id), .done_cnt(done_cnt)
    );

    cone_eval_arbiter #(.NUM_REQ(NR), .IN_W(W), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_vec(req_vec1),
        .req_ready(req_ready1), .cone_in(cone_in1), .cone_out(cone_out1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_ready(rsp_ready1),
        .busy(busy1), .grant_id(grant_id1), .done_cnt(done_cnt1)
    );

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= int'(NR); k++) begin
            if (v[(last + k) % int'(NR)]) return (last + k) % int'(NR);
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [NR-1:0] v);
        for (int k = 0; k < int'(NR); k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slice_of(input logic [NR*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        req_valid  = '0; req_vec  = '0; rsp_ready  = '0;
        req_valid1 = '0; req_vec1 = '0; rsp_ready1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (cone_in !== '0) begin n_fail++; $display("FAIL reset_cone_in: got %h want 0", cone_in); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if ({busy, rsp_data} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_data: got %b want 00", {busy, rsp_data}); end
        n_checks++; if ({grant_id, done_cnt} !== 11'd0) begin n_fail++; $display("FAIL reset_gid_cnt: got %h want 0", {grant_id, done_cnt}); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        req_vec = (NR*W)'({$urandom(), $urandom()});
        req_vec[0 +: W] = 9'h1FF;
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (cone_in !== 9'h1FF) begin n_fail++; $display("FAIL single_cone_in: got %h want 1ff", cone_in); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        lat = 1;
        while (rsp_valid == '0 && lat < 10) begin @(negedge clk); #1; lat++; end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", lat); end
        n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        n_checks++; if (rsp_data !== 1'b1) begin n_fail++; $display("FAIL single_rsp_data: got %b want 1", rsp_data); end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        n_checks++; if (done_cnt !== 8'd1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if ({busy, rsp_valid} !== 5'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", {busy, rsp_valid}); end
    endtask

    task automatic test_round_robin();
        int acc_cyc[$];
        int acc_id[$];
        int rsp_cyc[$];
        int idle_cnt;
        apply_reset();
        req_valid = '1;
        rsp_ready = '1;
        idle_cnt  = 0;
        for (int c = 0; c < 24; c++) begin
            req_vec = (NR*W)'({$urandom(), $urandom()});
            #1;
            if (req_ready != '0) begin acc_cyc.push_back(c); acc_id.push_back(first_set(req_ready)); end
            if (rsp_valid != '0) rsp_cyc.push_back(c);
            if (c <= 16 && busy == 1'b0) idle_cnt++;
            @(negedge clk);
        end
        req_valid = '0;
        n_checks++; if (acc_id.size() < 5 || rsp_cyc.size() < 5) begin
            n_fail++; $display("FAIL rr_count: got %0d grants %0d rsps want >=5", acc_id.size(), rsp_cyc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++; if (acc_id[k] != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, acc_id[k], k % 4); end
                n_checks++; if (acc_cyc[k] != 4 * k) begin n_fail++; $display("FAIL rr_accept_cyc[%0d]: got %0d want %0d", k, acc_cyc[k], 4 * k); end
                n_checks++; if (rsp_cyc[k] != 4 * k + 3) begin n_fail++; $display("FAIL rr_rsp_cyc[%0d]: got %0d want %0d", k, rsp_cyc[k], 4 * k + 3); end
            end
        end
        n_checks++; if (idle_cnt != 5) begin n_fail++; $display("FAIL rr_idle_cycles: got %0d want 5", idle_cnt); end
    endtask

    task automatic test_rotation();
        int n;
        apply_reset();
        rsp_ready = '1;
        req_vec   = (NR*W)'({$urandom(), $urandom()});
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rot_first: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rot_grant0: got %b want 0001", req_ready); end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL rot_gap0: got %0d want 3", n); end
        @(negedge clk);
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin @(negedge clk); #1; n++; end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rot_grant2: got %b want 0100", req_ready); end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL rot_gap2: got %0d want 3", n); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v;
        int n;
        apply_reset();
        req_vec   = (NR*W)'({$urandom(), $urandom()});
        v         = slice_of(req_vec, 1);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (rsp_valid == '0 && n < 10) begin @(negedge clk); #1; n++; end
        req_valid = '1;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp_valid k=%0d: got %b want 0010", k, rsp_valid); end
            n_checks++; if (rsp_data !== ^v) begin n_fail++; $display("FAIL bp_rsp_data k=%0d: got %b want %b", k, rsp_data, ^v); end
            n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_req_ready k=%0d: got %b want 0", k, req_ready); end
            n_checks++; if (cone_in !== v) begin n_fail++; $display("FAIL bp_cone_in k=%0d: got %h want %h", k, cone_in, v); end
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        #1;
        n_checks++; if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL bp_not_done: got %0d want 0", done_cnt); end
        @(negedge clk);
        rsp_ready = '0;
        #1;
        n_checks++; if (done_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL bp_rsp_drop: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_settle();
        apply_reset();
        rsp_ready = '1;
        req_vec   = (NR*W)'({$urandom(), $urandom()}) | (NR*W)'(1);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_pre_grant: got %b want 0100", req_ready); end
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({busy, done_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL mid_pre_state: got %h want 101", {busy, done_cnt}); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cone_in !== '0) begin n_fail++; $display("FAIL mid_cone_in: got %h want 0", cone_in); end
        n_checks++; if ({busy, rsp_data, rsp_valid, req_ready} !== 10'd0) begin
            n_fail++; $display("FAIL mid_ctrl: got %b want 0", {busy, rsp_data, rsp_valid, req_ready});
        end
        n_checks++; if ({grant_id, done_cnt} !== 11'd0) begin n_fail++; $display("FAIL mid_gid_cnt: got %h want 0", {grant_id, done_cnt}); end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_grant: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_random_traffic();
        int           m_last, m_gid, m_age, m_done, w;
        logic         m_busy;
        logic [W-1:0] m_cone;
        logic [NR-1:0] exp_rdy;
        apply_reset();
        m_last = int'(NR) - 1; m_gid = 0; m_age = 0; m_done = 0; m_busy = 1'b0; m_cone = '0;
        for (int c = 0; c < 2000; c++) begin
            req_valid = NR'($urandom());
            req_vec   = (NR*W)'({$urandom(), $urandom()});
            rsp_ready = NR'($urandom());
            #1;
            n_checks++; if (cone_in !== m_cone) begin n_fail++; $display("FAIL rnd_cone_in c=%0d: got %h want %h", c, cone_in, m_cone); end
            n_checks++; if (grant_id !== 3'(m_gid)) begin n_fail++; $display("FAIL rnd_grant_id c=%0d: got %0d want %0d", c, grant_id, m_gid); end
            n_checks++; if (done_cnt !== 8'(m_done)) begin n_fail++; $display("FAIL rnd_done_cnt c=%0d: got %0d want %0d", c, done_cnt, m_done); end
            n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_busy); end
            if (!m_busy) begin
                w = rr_pick(req_valid, m_last);
                exp_rdy = '0;
                if (w >= 0) exp_rdy[w] = 1'b1;
                n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_req_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
                n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rnd_idle_rsp c=%0d: got %b want 0", c, rsp_valid); end
                if (w >= 0) begin
                    m_busy = 1'b1; m_age = 0; m_gid = w; m_cone = slice_of(req_vec, w);
                end
            end else begin
                m_age++;
                exp_rdy = '0;
                if (m_age > int'(SC)) exp_rdy[m_gid] = 1'b1;
                n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rnd_busy_ready c=%0d: got %b want 0", c, req_ready); end
                n_checks++; if (rsp_valid !== exp_rdy) begin n_fail++; $display("FAIL rnd_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rdy); end
                if (m_age > int'(SC)) begin
                    n_checks++; if (rsp_data !== ^m_cone) begin n_fail++; $display("FAIL rnd_rsp_data c=%0d: got %b want %b", c, rsp_data, ^m_cone); end
                    if (rsp_ready[m_gid]) begin
                        m_busy = 1'b0; m_last = m_gid; m_done = (m_done + 1) % 256;
                    end
                end
            end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = '0;
    endtask

    task automatic test_wrap_settle1();
        int   done, acc, c;
        logic prev;
        apply_reset();
        done = 0; acc = -100; c = 0; prev = 1'b0;
        req_valid1 = 4'b0001;
        rsp_ready1 = 4'b0001;
        while (done < 256 && c < 1200) begin
            req_vec1 = (NR*W)'({$urandom(), $urandom()});
            #1;
            n_checks++; if (done_cnt1 !== 8'(done)) begin n_fail++; $display("FAIL wrap_cnt c=%0d: got %0d want %0d", c, done_cnt1, done % 256); end
            if (req_ready1 != '0) acc = c;
            if (rsp_valid1 != '0) begin
                if (!prev) begin
                    n_checks++; if (c - acc != 2) begin n_fail++; $display("FAIL wrap_latency c=%0d: got %0d want 2", c, c - acc); end
                end
                if (rsp_valid1[0] && rsp_ready1[0]) done++;
            end
            prev = (rsp_valid1 != '0);
            @(negedge clk);
            c++;
        end
        #1;
        n_checks++; if (done != 256) begin n_fail++; $display("FAIL wrap_timeout: got %0d transactions want 256", done); end
        n_checks++; if (done_cnt1 !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", done_cnt1); end
        req_valid1 = '0; rsp_ready1 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rotation();
        test_backpressure();
        test_reset_mid_settle();
        test_random_traffic();
        test_wrap_settle1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
